// File: rtl/led_scan_if.sv
// Control pulses and decoder-side outputs of the LED scan sequencer.
// The master side is the pulse source; the slave side is the sequencer.
interface led_scan_if;
  logic       start;
  logic       stop;
  logic       step;
  logic [1:0] mode;
  logic       dec_en;
  logic [2:0] dec_a;
  logic       running;
  logic       wrap;

  modport master (
    output start, stop, step, mode,
    input  dec_en, dec_a, running, wrap
  );

  modport slave (
    input  start, stop, step, mode,
    output dec_en, dec_a, running, wrap
  );
endinterface

// File: rtl/led_scan_sequencer.sv
// Steps the lit LED position across 0..7 for a 3-to-8 decoder at a programmable rate.
// Supports up/down/bounce/hold patterns with run, pause, single-step and stop control.
module led_scan_sequencer #(
  parameter int DIV   = 25000000,
  parameter int DIV_W = 25
) (
  input  logic      clk,
  input  logic      rst_n,
  led_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_t             state, state_nxt;
  logic [2:0]         pos, pos_nxt;
  logic               dir, dir_nxt;     // 1 = moving down
  logic [DIV_W-1:0]   cnt, cnt_nxt;
  logic               wrap_nxt;
  logic               en_q, run_q, wrap_q;
  logic [4:0]         adv;

  // Result packed as {wrap, dir, pos}; mode is sampled at the moment of advance.
  function automatic logic [4:0] advance(input logic [2:0] p, input logic d,
                                         input logic [1:0] m);
    logic [4:0] r;
    r = {1'b0, d, p};
    case (m)
      2'b00: r = {(p == 3'd7), 1'b0, p + 3'd1};
      2'b01: r = {(p == 3'd0), 1'b1, p - 3'd1};
      2'b10: begin
        if (!d) r = (p == 3'd7) ? {1'b1, 1'b1, 3'd6} : {1'b0, 1'b0, p + 3'd1};
        else    r = (p == 3'd0) ? {1'b1, 1'b0, 3'd1} : {1'b0, 1'b1, p - 3'd1};
      end
      default: r = {1'b0, d, p};
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    adv       = advance(pos, dir, bus.mode);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.start && !bus.stop) begin
          state_nxt = RUN;
          pos_nxt   = (bus.mode == 2'b01) ? 3'd7 : 3'd0;
          dir_nxt   = (bus.mode == 2'b01);
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = PAUSE;
        end else if (cnt == DIV_LAST) begin
          cnt_nxt                     = '0;
          {wrap_nxt, dir_nxt, pos_nxt} = adv;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PAUSE: begin
        // Stop beats start, and any other pulse beats step.
        if (bus.stop) begin
          state_nxt = IDLE;
          pos_nxt   = 3'd0;
          cnt_nxt   = '0;
        end else if (bus.start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (bus.step) begin
          {wrap_nxt, dir_nxt, pos_nxt} = adv;
        end
      end
      default: begin
        state_nxt = IDLE;
        pos_nxt   = 3'd0;
        dir_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pos    <= 3'd0;
      dir    <= 1'b0;
      cnt    <= '0;
      en_q   <= 1'b0;
      run_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      dir    <= dir_nxt;
      cnt    <= cnt_nxt;
      en_q   <= (state_nxt != IDLE);
      run_q  <= (state_nxt == RUN);
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.dec_a   = pos;
  assign bus.dec_en  = en_q;
  assign bus.running = run_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer: one instance at DIV=4, one at DIV=1.
module tb_led_scan_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  led_scan_if a_if();
  led_scan_if b_if();

  led_scan_sequencer #(.DIV(4), .DIV_W(3)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a_if.slave)
  );

  led_scan_sequencer #(.DIV(1), .DIV_W(1)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed{en,run,wrap,a}=%b_%b_%b_%0d expected=%b_%b_%b_%0d",
             tag, obs[5], obs[4], obs[3], obs[2:0], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic chka(input string tag, input logic en, input logic run,
                      input logic wr, input logic [2:0] a);
    chk(tag, {a_if.dec_en, a_if.running, a_if.wrap, a_if.dec_a}, {en, run, wr, a});
  endtask

  task automatic chkb(input string tag, input logic en, input logic run,
                      input logic wr, input logic [2:0] a);
    chk(tag, {b_if.dec_en, b_if.running, b_if.wrap, b_if.dec_a}, {en, run, wr, a});
  endtask

  task automatic pulse_a(input logic s, input logic p, input logic st);
    a_if.start = s;
    a_if.stop  = p;
    a_if.step  = st;
    tick();
    a_if.start = 1'b0;
    a_if.stop  = 1'b0;
    a_if.step  = 1'b0;
  endtask

  task automatic pulse_b(input logic s, input logic p, input logic st);
    b_if.start = s;
    b_if.stop  = p;
    b_if.step  = st;
    tick();
    b_if.start = 1'b0;
    b_if.stop  = 1'b0;
    b_if.step  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] seq3 [13];
    logic [2:0] seq6 [15];
    logic [2:0] prev;
    seq3 = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
    seq6 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2,
             3'd1, 3'd0, 3'd1};
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a_if.start = 1'b0; a_if.stop = 1'b0; a_if.step = 1'b0; a_if.mode = 2'b00;
    b_if.start = 1'b0; b_if.stop = 1'b0; b_if.step = 1'b0; b_if.mode = 2'b00;

    // Reset state
    tick();
    chka("rst_a", 1'b0, 1'b0, 1'b0, 3'd0);
    chkb("rst_b", 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chka("idle_a", 1'b0, 1'b0, 1'b0, 3'd0);

    // Up sweep, DIV=4
    a_if.mode = 2'b00;
    pulse_a(1'b1, 1'b0, 1'b0);
    chka("t2_start", 1'b1, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 32; k++) begin
      chka("t2_up", 1'b1, 1'b1, 1'b0, 3'(k / 4));
      tick();
    end
    chka("t2_wrap", 1'b1, 1'b1, 1'b1, 3'd0);
    tick();
    chka("t2_wrap_clr", 1'b1, 1'b1, 1'b0, 3'd0);
    pulse_a(1'b0, 1'b1, 1'b0);
    chka("t2_pause", 1'b1, 1'b0, 1'b0, 3'd0);
    pulse_a(1'b0, 1'b1, 1'b0);
    chka("t2_idle", 1'b0, 1'b0, 1'b0, 3'd0);

    // Down sweep, then switch to bounce at pos 5 heading down
    a_if.mode = 2'b01;
    pulse_a(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      chka("t3_down", 1'b1, 1'b1, 1'b0, 3'(7 - k / 4));
      tick();
    end
    chka("t3_wrap", 1'b1, 1'b1, 1'b1, 3'd7);
    repeat (8) tick();
    chka("t3_at5", 1'b1, 1'b1, 1'b0, 3'd5);
    a_if.mode = 2'b10;
    prev = 3'd5;
    for (int i = 0; i < 13; i++) begin
      repeat (3) tick();
      chka("t3_hold", 1'b1, 1'b1, 1'b0, prev);
      tick();
      chka("t3_bounce", 1'b1, 1'b1, (i == 5 || i == 12), seq3[i]);
      prev = seq3[i];
    end
    pulse_a(1'b0, 1'b1, 1'b0);
    pulse_a(1'b0, 1'b1, 1'b0);
    chka("t3_idle", 1'b0, 1'b0, 1'b0, 3'd0);

    // Pause, step, resume, stop
    a_if.mode = 2'b00;
    pulse_a(1'b1, 1'b0, 1'b0);
    repeat (12) tick();
    chka("t4_at3", 1'b1, 1'b1, 1'b0, 3'd3);
    pulse_a(1'b0, 1'b1, 1'b0);
    chka("t4_pause", 1'b1, 1'b0, 1'b0, 3'd3);
    for (int k = 0; k < 20; k++) begin
      tick();
      chka("t4_held", 1'b1, 1'b0, 1'b0, 3'd3);
    end
    pulse_a(1'b0, 1'b0, 1'b1);
    chka("t4_step", 1'b1, 1'b0, 1'b0, 3'd4);
    tick();
    chka("t4_step_once", 1'b1, 1'b0, 1'b0, 3'd4);
    pulse_a(1'b1, 1'b0, 1'b0);
    chka("t4_resume", 1'b1, 1'b1, 1'b0, 3'd4);
    repeat (3) begin
      tick();
      chka("t4_full", 1'b1, 1'b1, 1'b0, 3'd4);
    end
    tick();
    chka("t4_adv", 1'b1, 1'b1, 1'b0, 3'd5);
    pulse_a(1'b0, 1'b1, 1'b0);
    chka("t4_pause2", 1'b1, 1'b0, 1'b0, 3'd5);
    pulse_a(1'b0, 1'b1, 1'b0);
    chka("t4_idle", 1'b0, 1'b0, 1'b0, 3'd0);

    // Ignored and simultaneous pulses, hold mode
    pulse_a(1'b0, 1'b0, 1'b1);
    chka("t5_idle_step", 1'b0, 1'b0, 1'b0, 3'd0);
    pulse_a(1'b1, 1'b1, 1'b0);
    chka("t5_idle_startstop", 1'b0, 1'b0, 1'b0, 3'd0);
    pulse_a(1'b0, 1'b1, 1'b0);
    chka("t5_idle_stop", 1'b0, 1'b0, 1'b0, 3'd0);
    pulse_a(1'b1, 1'b0, 1'b0);
    chka("t5_start", 1'b1, 1'b1, 1'b0, 3'd0);
    pulse_a(1'b0, 1'b0, 1'b1);
    chka("t5_run_step", 1'b1, 1'b1, 1'b0, 3'd0);
    repeat (2) tick();
    chka("t5_run_pre", 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    chka("t5_run_adv", 1'b1, 1'b1, 1'b0, 3'd1);
    pulse_a(1'b1, 1'b1, 1'b0);
    chka("t5_run_startstop", 1'b1, 1'b0, 1'b0, 3'd1);
    pulse_a(1'b1, 1'b0, 1'b1);
    chka("t5_start_step", 1'b1, 1'b1, 1'b0, 3'd1);
    a_if.mode = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
      chka("t5_hold", 1'b1, 1'b1, 1'b0, 3'd1);
    end
    pulse_a(1'b0, 1'b1, 1'b1);
    chka("t5_stop_step_run", 1'b1, 1'b0, 1'b0, 3'd1);
    pulse_a(1'b0, 1'b1, 1'b1);
    chka("t5_stop_step_pause", 1'b0, 1'b0, 1'b0, 3'd0);

    // DIV=1 bounce
    b_if.mode = 2'b10;
    pulse_b(1'b1, 1'b0, 1'b0);
    chkb("t6_start", 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chkb("t6_bounce", 1'b1, 1'b1, (i == 7 || i == 14), seq6[i]);
    end
    pulse_b(1'b0, 1'b1, 1'b0);
    chkb("t6_pause", 1'b1, 1'b0, 1'b0, 3'd1);
    pulse_b(1'b0, 1'b1, 1'b0);
    chkb("t6_idle", 1'b0, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset mid-run
    a_if.mode = 2'b00;
    pulse_a(1'b1, 1'b0, 1'b0);
    repeat (20) tick();
    chka("t1_at5", 1'b1, 1'b1, 1'b0, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chka("t1_async", 1'b0, 1'b0, 1'b0, 3'd0);
    tick(); tick();
    chka("t1_in_rst", 1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    repeat (6) tick();
    chka("t1_idle_after", 1'b0, 1'b0, 1'b0, 3'd0);
    pulse_a(1'b1, 1'b0, 1'b0);
    chka("t1_restart", 1'b1, 1'b1, 1'b0, 3'd0);
    repeat (4) tick();
    chka("t1_restart_adv", 1'b1, 1'b1, 1'b0, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_scan_sequencer.md
Name: led_scan_sequencer

Overview:
- Sequencer that drives the enable and 3-bit select of the 3-to-8 LED decoder, stepping the lit LED across positions 0..7 at a programmable rate.
- Supports up, down, bounce and hold patterns, plus run, pause, single-step and stop control.
- Sits between the board-level control pulses (debounced buttons or the top-level FSM) and the decoder's en/a inputs.

Parameters:
- DIV, 25000000, clock cycles per position advance; legal range 1..2^DIV_W-1.
- DIV_W, 25, width of the prescaler counter; must satisfy DIV <= 2^DIV_W-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; IDLE->RUN, or PAUSE->RUN (resume).
- stop  in  1  one-cycle pulse; RUN->PAUSE, or PAUSE->IDLE.
- step  in  1  one-cycle pulse; single advance, honoured only in PAUSE.
- mode  in  2  00 up, 01 down, 10 bounce, 11 hold.
- dec_en  out  1  decoder enable; registered.
- dec_a  out  3  decoder select (current position); registered.
- running  out  1  high while in RUN; registered.
- wrap  out  1  one-cycle pulse marking an end-of-sweep advance; registered.

Behaviour:
- Reset (rst_n low, at any time including mid-run):
  - State IDLE, pos=0, dir=up, prescaler=0.
  - dec_en=0, dec_a=0, running=0, wrap=0.
- States:
  - IDLE: dec_en=0, dec_a=0, prescaler held at 0.
  - RUN: dec_en=1, running=1, prescaler counts.
  - PAUSE: dec_en=1, running=0, pos and prescaler held.
- Transitions:
  - IDLE + start -> RUN. pos loads 7 if mode=01, else 0. dir=up, or down if mode=01. Prescaler cleared.
  - RUN + stop -> PAUSE.
  - PAUSE + start -> RUN, prescaler cleared so a full DIV period precedes the next advance.
  - PAUSE + stop -> IDLE, pos cleared to 0.
  - IDLE + stop and IDLE + step: ignored.
- Simultaneous pulses:
  - start and stop in the same cycle: stop wins (RUN->PAUSE, PAUSE->IDLE, IDLE stays IDLE).
  - step together with start or stop: step ignored.
- Latency: start sampled at edge n; RUN, dec_en=1 and the initial pos are visible after edge n.
- Prescaler:
  - In RUN, counts 0..DIV-1.
  - When it equals DIV-1, an advance occurs and the count returns to 0.
  - First advance is visible DIV cycles after the start edge.
  - DIV=1 advances every cycle.
- Advance rule (mode sampled at each advance; a mode change takes effect at the next advance):
  - up: pos+1, 7 wraps to 0 with wrap=1.
  - down: pos-1, 0 wraps to 7 with wrap=1.
  - bounce: move in dir. At pos 7 with dir=up: dir<=down, pos<=6, wrap=1. At pos 0 with dir=down: dir<=up, pos<=1, wrap=1. Entering bounce keeps the current dir; up/down modes also set dir to match.
  - hold: pos unchanged, wrap=0, prescaler keeps running.
- Step in PAUSE: performs exactly one advance under the same rule. New pos and wrap are visible after the next edge. Prescaler untouched.
- wrap: high for exactly one cycle, coincident with the new pos. Never asserted outside an advance.
- All arithmetic is modulo 8 on a 3-bit pos. Prescaler never exceeds DIV-1.

Test Plan:
1. DIV=4. Assert rst_n low mid-RUN at pos 5. Required: dec_en=0, dec_a=0, running=0, wrap=0 immediately, without waiting for a clk edge. After release, IDLE with no activity until start.
2. DIV=4, mode=00, start pulse. Required: dec_a=0 for 4 cycles, then 1,2,...,7 each held 4 cycles. Then 0 with wrap=1 for one cycle, 32 cycles after start. dec_en=1 and running=1 throughout.
3. DIV=4, mode=01, start. Required: dec_a=7 first, then 6..0, then 7 with wrap=1. Then switch to mode=10 while at pos 5 going down. Required: 4,3,2,1,0, then 1 with wrap=1 on the 0->1 advance, then up to 7, then 6 with wrap=1.
4. DIV=4, mode=00. Stop when dec_a=3. Required: running=0, dec_en=1, dec_a held at 3 for 20 cycles. Step pulse gives dec_a=4 next cycle. Start gives dec_a=4 for a full 4 cycles, then 5. A second stop followed by stop gives IDLE with dec_en=0, dec_a=0.
5. Simultaneous start+stop: in RUN -> PAUSE; in IDLE -> stays IDLE with dec_en=0. Step pulse in RUN or IDLE -> no change to dec_a. mode=11 in RUN -> dec_a frozen, wrap never asserted.
6. DIV=1, mode=10. Required: dec_a advances every cycle, 0,1,...,7,6,...,0,1. wrap=1 exactly on the cycles showing 6 after 7 and 1 after 0.
